// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer
//
// Sits between the hps_io ioctl download stream and an arcade core.
//  - Steers ROM download bytes into a shared single-port program/sound ROM RAM.
//  - Shares that RAM port between download writes and core CPU reads using a
//    req/ack handshake. Download writes always win the port.
//  - Latches the DIP bank and the mod byte from their own ioctl indices.
//  - Sequences core reset: held during a ROM load, then for HOLD_CYCLES
//    cycles afterwards. The same hold also applies after power-on reset.
//
// Ports
//  clk_sys, reset              : system clock, asynchronous active-high reset
//  ioctl_download/index/wr/addr/dout : hps_io download stream
//  ext_reset                   : OSD/button reset request (level)
//  cpu_rd_req, cpu_addr        : core read request, held until cpu_rd_ack
//  cpu_rd_ack, cpu_rd_data     : one-cycle completion pulse with read data
//  mem_addr, mem_we, mem_din   : RAM port (combinational mux)
//  mem_dout                    : RAM read data, one cycle after the address
//  core_reset                  : registered reset to the core
//  rom_loading                 : high while a ROM load is in progress
//  dip_sw                      : DIP bank, byte k at [8k+7:8k]
//  mod_byte                    : last mod byte written
//  dl_err                      : sticky ROM address overflow flag
module rom_dl_sequencer #(
  parameter int          ADDR_W      = 17,
  parameter int          HOLD_CYCLES = 1024,
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [7:0]  MOD_INDEX   = 8'd1,
  parameter logic [7:0]  DIP_INDEX   = 8'd254
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ext_reset,
  input  logic              cpu_rd_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_rd_ack,
  output logic [7:0]        cpu_rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              core_reset,
  output logic              rom_loading,
  output logic [63:0]       dip_sw,
  output logic [7:0]        mod_byte,
  output logic              dl_err
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int              CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              core_reset_q, core_reset_d;
  logic              rom_loading_q, rom_loading_d;
  logic              dl_err_q, dl_err_d;
  logic [63:0]       dip_sw_q, dip_sw_d;
  logic [7:0]        mod_byte_q, mod_byte_d;
  logic              dl_prev_q, dl_prev_d;
  logic              rd_p1_q, rd_p1_d;
  logic              rd_ack_q, rd_ack_d;
  logic [7:0]        rd_data_q, rd_data_d;

  logic rom_sel;
  logic rom_wr_req;
  logic addr_ok;
  logic rom_we;
  logic rom_ovf;
  logic dl_start;
  logic dip_wr;
  logic mod_wr;
  logic rd_issue;

  // ROM write decode. Out-of-range addresses never reach the RAM; they only
  // raise the sticky error flag.
  assign rom_sel    = (ioctl_index == ROM_INDEX);
  assign rom_wr_req = ioctl_wr & rom_sel & ioctl_download;
  assign addr_ok    = ((ioctl_addr >> ADDR_W) == '0);
  assign rom_we     = rom_wr_req & addr_ok;
  assign rom_ovf    = rom_wr_req & ~addr_ok;

  // A load only starts on a rising download edge. dl_prev_q resets high so a
  // stream already running when reset is released is ignored until it drops.
  assign dl_start = ioctl_download & ~dl_prev_q & rom_sel;

  assign dip_wr = ioctl_wr & (ioctl_index == DIP_INDEX) & (ioctl_addr[24:3] == 22'd0);
  assign mod_wr = ioctl_wr & (ioctl_index == MOD_INDEX);

  // A read may issue only with nothing in flight (p1 stage or ack cycle),
  // when the download is not using the port, and never during LOAD.
  assign rd_issue = cpu_rd_req & ~rd_p1_q & ~rd_ack_q & ~rom_we & (state_q != LOAD);

  assign mem_we   = rom_we;
  assign mem_addr = rom_we ? ioctl_addr[ADDR_W-1:0] : cpu_addr;
  assign mem_din  = ioctl_dout;

  // Reset sequencing FSM: next state, hold counter and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (dl_start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!ioctl_download) begin
          state_d = HOLD;
          cnt_d   = HOLD_LAST;
        end
      end
      HOLD: begin
        if (dl_start) begin
          state_d = LOAD;
        end else if (ext_reset) begin
          cnt_d = HOLD_LAST;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = HOLD_LAST;
      end
    endcase

    core_reset_d  = (state_d == RUN) ? ext_reset : 1'b1;
    rom_loading_d = (state_d == LOAD);

    // Overflow in the very cycle a load starts belongs to the new load, so
    // the set takes priority over the entry clear.
    dl_err_d = dl_err_q;
    if ((state_d == LOAD) && (state_q != LOAD)) begin
      dl_err_d = 1'b0;
    end
    if (rom_ovf) begin
      dl_err_d = 1'b1;
    end
  end

  // Side-channel latches and the two-stage read return pipeline.
  always_comb begin
    dip_sw_d = dip_sw_q;
    if (dip_wr) begin
      dip_sw_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
    end

    mod_byte_d = mod_byte_q;
    if (mod_wr) begin
      mod_byte_d = ioctl_dout;
    end

    dl_prev_d = ioctl_download;

    rd_p1_d   = rd_issue;
    rd_ack_d  = rd_p1_q;
    rd_data_d = rd_p1_q ? mem_dout : rd_data_q;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= HOLD;
      cnt_q         <= HOLD_LAST;
      core_reset_q  <= 1'b1;
      rom_loading_q <= 1'b0;
      dl_err_q      <= 1'b0;
      dip_sw_q      <= '0;
      mod_byte_q    <= '0;
      dl_prev_q     <= 1'b1;
      rd_p1_q       <= 1'b0;
      rd_ack_q      <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      core_reset_q  <= core_reset_d;
      rom_loading_q <= rom_loading_d;
      dl_err_q      <= dl_err_d;
      dip_sw_q      <= dip_sw_d;
      mod_byte_q    <= mod_byte_d;
      dl_prev_q     <= dl_prev_d;
      rd_p1_q       <= rd_p1_d;
      rd_ack_q      <= rd_ack_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign core_reset  = core_reset_q;
  assign rom_loading = rom_loading_q;
  assign dl_err      = dl_err_q;
  assign dip_sw      = dip_sw_q;
  assign mod_byte    = mod_byte_q;
  assign cpu_rd_ack  = rd_ack_q;
  assign cpu_rd_data = rd_data_q;

endmodule

// File: doc/rom_dl_sequencer.md
Name: rom_dl_sequencer

Overview:
- Sits between hps_io's ioctl download stream and the arcade core.
- Steers ROM download bytes into a shared single-port program/sound ROM RAM.
- Shares that RAM port between download writes and core CPU reads with a req/ack handshake.
- Latches the DIP bank and the mod byte, and sequences core reset across download: held in reset during load, then for a fixed number of cycles afterwards.

Parameters:
ADDR_W, 17, ROM RAM address width in bytes.
HOLD_CYCLES, 1024, post-download and power-on reset hold length in clk_sys cycles (>=1).
ROM_INDEX, 0, ioctl_index value for ROM data.
MOD_INDEX, 1, ioctl_index value for the mod byte.
DIP_INDEX, 254, ioctl_index value for the DIP bank.

Ports:
clk_sys  in  1  system clock, all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
ioctl_download  in  1  download active.
ioctl_index  in  8  download target index.
ioctl_wr  in  1  one-cycle byte strobe.
ioctl_addr  in  25  byte address.
ioctl_dout  in  8  byte data.
ext_reset  in  1  OSD/button reset request, level.
cpu_rd_req  in  1  core read request, held until ack.
cpu_addr  in  ADDR_W  core read address, stable while req high.
cpu_rd_ack  out  1  one-cycle read-complete pulse.
cpu_rd_data  out  8  read data, valid when ack high.
mem_addr  out  ADDR_W  RAM address, combinational mux.
mem_we  out  1  RAM write enable.
mem_din  out  8  RAM write data.
mem_dout  in  8  RAM read data, 1-cycle synchronous latency.
core_reset  out  1  registered reset to core.
rom_loading  out  1  high in LOAD, for the LED.
dip_sw  out  64  DIP bytes; byte k at [8k+7:8k].
mod_byte  out  8  last mod byte written.
dl_err  out  1  sticky ROM address overflow flag.

Behaviour:
- Async reset values:
  - state=HOLD, hold counter=HOLD_CYCLES-1, core_reset=1.
  - cpu_rd_ack=0, cpu_rd_data=0, dip_sw=0, mod_byte=0, dl_err=0, rom_loading=0.
  - Read pipeline empty.
- FSM states RUN, LOAD, HOLD; evaluated each clk_sys edge.
  - RUN: core_reset=ext_reset (registered). On ioctl_download=1 with ioctl_index==ROM_INDEX, go to LOAD.
  - LOAD: core_reset=1, rom_loading=1. dl_err cleared on LOAD entry. When ioctl_download falls, go to HOLD and load counter=HOLD_CYCLES-1.
  - HOLD: core_reset=1; counter decrements each cycle; at 0 go to RUN (core_reset=0 next cycle unless ext_reset). ext_reset high in HOLD reloads the counter. ROM download start in HOLD goes to LOAD.
- ROM write:
  - Condition: ioctl_wr & ioctl_index==ROM_INDEX & ioctl_download.
  - If ioctl_addr < 2^ADDR_W: mem_we=1, mem_addr=ioctl_addr[ADDR_W-1:0], mem_din=ioctl_dout, same cycle.
  - Otherwise no write and dl_err<=1.
- DIP write:
  - Condition: ioctl_wr & ioctl_index==DIP_INDEX & ioctl_addr[24:3]==0.
  - Writes dip_sw byte ioctl_addr[2:0] next edge. Accepted in any state; never touches RAM or core_reset.
- Mod write: ioctl_wr & ioctl_index==MOD_INDEX sets mod_byte<=ioctl_dout. Accepted in any state.
- Read arbitration:
  - Download write has absolute priority on the RAM port.
  - A read issues in cycle N when cpu_rd_req=1, no read is pending, and no ROM write occurs in cycle N. Then mem_addr=cpu_addr, mem_we=0.
  - cpu_rd_data<=mem_dout at the end of N+1; cpu_rd_ack=1 in cycle N+2 for exactly one cycle.
  - req is not re-sampled until the cycle after ack, so at most one read is in flight.
  - A write colliding with a pending request only delays issue. No read is lost or duplicated.
- Reads in LOAD are stalled: not issued, no ack.
- If LOAD is entered with a read in flight, that read still completes and acks.
- Async reset mid-download drops all partial state. The in-progress stream is then ignored until ioctl_download is re-seen rising while in RUN or HOLD.
- Idle port: mem_addr=cpu_addr, mem_we=0, mem_din=ioctl_dout.

Test Plan:
- Power-on: release reset, no stimulus -> core_reset=1 for exactly 1024 cycles, then 0; dip_sw=0, mod_byte=0.
- ROM load: index 0, write 0xA5 at addr 0x00010 then 0x5A at 0x1FFFF -> mem_we pulses with those addr/data; rom_loading=1 throughout; download falls -> core_reset stays 1 for 1024 more cycles.
- Overflow: index 0 write at addr 0x20000 -> mem_we=0, dl_err=1; next download start -> dl_err=0.
- DIP/mod: index 254, addr 2, data 0xC2 -> dip_sw[23:16]=0xC2; addr 8 -> no change; index 1, data 0x01 -> mod_byte=0x01, core_reset unaffected in RUN.
- Read handshake: RUN, req with addr 0x00010 (RAM holds 0xA5) -> ack one cycle 2 cycles after issue with data 0xA5; back-to-back requests -> one ack per read, no overlap.
- Collision: ROM write in the same cycle as req -> write occurs, read issues next cycle, ack 3 cycles after req rose; ext_reset pulse in HOLD -> counter restarts at 1023.
